// File: rtl/VX_gpu_pkg.sv
// Shared GPU definitions used by the warp barrier controller.
//   bar_state_t : per-barrier state (IDLE, GREQ, GWAIT).
//   clog2_min1  : address width helper that never returns 0.
// The request/response structs (barrier_t, gbar_req_t, gbar_rsp_t) depend on
// the instantiating module's parameters, so they are declared inside it.
package VX_gpu_pkg;

    typedef enum logic [1:0] {
        BAR_IDLE  = 2'd0,
        BAR_GREQ  = 2'd1,
        BAR_GWAIT = 2'd2
    } bar_state_t;

    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/VX_priority_encoder.sv
// Lowest-index-first priority encoder.
//   req   : request vector (N bits)
//   index : index of the lowest set bit (0 when none)
//   valid : any bit set
module VX_priority_encoder #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req,
    output logic [W-1:0] index,
    output logic         valid
);

    // Scan from the top so the lowest set bit is the last one written.
    always_comb begin
        index = '0;
        valid = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                index = W'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vx_barrier_ctrl.sv
// Per-core warp barrier controller.
// Tracks arrivals per barrier ID, keeps arriving warps stalled and releases
// them together in one registered pulse once the expected count is reached.
// With VX_GBAR_EN defined, global barriers are forwarded to a cluster barrier
// unit over a valid/ready request link and released on its response; without
// it, global requests behave as local ones and the gbar link is tied off.
// Ports:
//   clk, reset_n                 : clock, synchronous active-low reset
//   bar_*                        : barrier request from execute (always accepted)
//   stalled_mask                 : warps blocked on any barrier
//   release_valid / release_mask : one-cycle release pulse and warps released
//   gbar_req_*                   : global barrier request (valid/ready)
//   gbar_rsp_valid / gbar_rsp_id : global barrier completion
module vx_barrier_ctrl
    import VX_gpu_pkg::*;
#(
    parameter int  NUM_WARPS    = 4,
    parameter int  NUM_BARRIERS = 4,
    parameter int  NC_WIDTH     = 2,
    parameter int  CORE_ID      = 0,
    localparam int NW_WIDTH     = clog2_min1(NUM_WARPS),
    localparam int NB_WIDTH     = clog2_min1(NUM_BARRIERS)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 bar_valid,
    input  logic [NW_WIDTH-1:0]  bar_wid,
    input  logic [NB_WIDTH-1:0]  bar_id,
    input  logic                 bar_is_global,
    input  logic [NW_WIDTH-1:0]  bar_size_m1,
    input  logic [NC_WIDTH-1:0]  bar_gsize_m1,
    input  logic                 bar_is_noop,
    output logic [NUM_WARPS-1:0] stalled_mask,
    output logic                 release_valid,
    output logic [NUM_WARPS-1:0] release_mask,
    output logic                 gbar_req_valid,
    input  logic                 gbar_req_ready,
    output logic [NB_WIDTH-1:0]  gbar_req_id,
    output logic [NC_WIDTH-1:0]  gbar_req_size_m1,
    output logic [NC_WIDTH-1:0]  gbar_req_core_id,
    input  logic                 gbar_rsp_valid,
    input  logic [NB_WIDTH-1:0]  gbar_rsp_id
);

    typedef struct packed {
        logic                valid;
        logic [NW_WIDTH-1:0] wid;
        logic [NB_WIDTH-1:0] id;
        logic                is_global;
        logic [NW_WIDTH-1:0] size_m1;
        logic [NC_WIDTH-1:0] gsize_m1;
        logic                is_noop;
    } barrier_t;

    typedef struct packed {
        logic [NB_WIDTH-1:0] id;
        logic [NC_WIDTH-1:0] size_m1;
        logic [NC_WIDTH-1:0] core_id;
    } gbar_req_t;

    typedef struct packed {
        logic [NB_WIDTH-1:0] id;
    } gbar_rsp_t;

    barrier_t  bar;
    gbar_rsp_t rsp;
    gbar_req_t req;

    assign bar = '{valid: bar_valid, wid: bar_wid, id: bar_id, is_global: bar_is_global,
                   size_m1: bar_size_m1, gsize_m1: bar_gsize_m1, is_noop: bar_is_noop};
    assign rsp = '{id: gbar_rsp_id};

    logic [NW_WIDTH-1:0]  count_r [NUM_BARRIERS];
    logic [NUM_WARPS-1:0] mask_r  [NUM_BARRIERS];
    logic                 release_valid_r;
    logic [NUM_WARPS-1:0] release_mask_r;

    logic [NUM_WARPS-1:0]    wid_bit;
    logic                    bar_is_idle;
    logic                    arrive;
    logic                    is_final;
    logic                    arrive_global;
    logic [NUM_WARPS-1:0]    local_rel;
    logic [NUM_WARPS-1:0]    rsp_rel;
    logic [NUM_WARPS-1:0]    stall_or;
    logic [NUM_BARRIERS-1:0] greq_vec;
    logic [NB_WIDTH-1:0]     pe_id;
    logic                    pe_valid;
    logic                    req_valid;

    VX_priority_encoder #(
        .N (NUM_BARRIERS),
        .W (NB_WIDTH)
    ) u_greq_sel (
        .req   (greq_vec),
        .index (pe_id),
        .valid (pe_valid)
    );

`ifdef VX_GBAR_EN
    bar_state_t          state_r [NUM_BARRIERS];
    logic [NC_WIDTH-1:0] gsize_r [NUM_BARRIERS];
    logic                hold_vld_r;
    logic [NB_WIDTH-1:0] hold_id_r;
    logic [NB_WIDTH-1:0] sel_id;
    logic                req_fire;
    logic                rsp_hit;

    assign bar_is_idle   = (state_r[bar.id] == BAR_IDLE);
    assign arrive_global = bar.is_global;
    // Responses for barriers not waiting (e.g. stale ones across a reset) are dropped.
    assign rsp_hit       = gbar_rsp_valid && (state_r[rsp.id] == BAR_GWAIT);
    assign rsp_rel       = rsp_hit ? mask_r[rsp.id] : '0;

    always_comb begin
        greq_vec = '0;
        for (int b = 0; b < NUM_BARRIERS; b++) begin
            greq_vec[b] = (state_r[b] == BAR_GREQ);
        end
    end

    // A request presented while ready is low stays on the same ID even if a
    // lower ID enters GREQ meanwhile, keeping the valid/ready payload stable.
    assign sel_id    = hold_vld_r ? hold_id_r : pe_id;
    assign req_valid = pe_valid;
    assign req_fire  = req_valid && gbar_req_ready;
    assign req       = '{id: sel_id, size_m1: gsize_r[sel_id], core_id: NC_WIDTH'(CORE_ID)};

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            hold_vld_r <= 1'b0;
            hold_id_r  <= '0;
            for (int b = 0; b < NUM_BARRIERS; b++) begin
                state_r[b] <= BAR_IDLE;
            end
        end else begin
            hold_vld_r <= req_valid && !gbar_req_ready;
            hold_id_r  <= sel_id;
            for (int b = 0; b < NUM_BARRIERS; b++) begin
                if (arrive && is_final && arrive_global && (bar.id == NB_WIDTH'(b))) begin
                    state_r[b] <= BAR_GREQ;
                    gsize_r[b] <= bar.gsize_m1;
                end else if (req_fire && (sel_id == NB_WIDTH'(b))) begin
                    state_r[b] <= BAR_GWAIT;
                end else if (rsp_hit && (rsp.id == NB_WIDTH'(b))) begin
                    state_r[b] <= BAR_IDLE;
                end
            end
        end
    end

    a_arrive_idle: assert property (@(posedge clk) disable iff (!reset_n)
        (bar_valid && !bar_is_noop) |-> (state_r[bar_id] == BAR_IDLE));
    a_rsp_waiting: assert property (@(posedge clk) disable iff (!reset_n)
        gbar_rsp_valid |-> (state_r[gbar_rsp_id] == BAR_GWAIT));
`else
    logic unused_gbar;

    assign bar_is_idle   = 1'b1;
    assign arrive_global = 1'b0;
    assign rsp_rel       = '0;
    assign greq_vec      = '0;
    assign req_valid     = 1'b0;
    assign req           = '0;
    assign unused_gbar   = &{1'b0, bar.is_global, bar.gsize_m1, gbar_req_ready,
                             gbar_rsp_valid, rsp.id, pe_id, pe_valid};
`endif

    assign wid_bit  = NUM_WARPS'(1) << bar.wid;
    assign arrive   = bar.valid && !bar.is_noop && bar_is_idle;
    assign is_final = (count_r[bar.id] == bar.size_m1);

    always_comb begin
        local_rel = '0;
        if (arrive && is_final && !arrive_global) begin
            local_rel = mask_r[bar.id] | wid_bit;
        end
    end

    always_comb begin
        stall_or = '0;
        for (int b = 0; b < NUM_BARRIERS; b++) begin
            stall_or = stall_or | mask_r[b];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int b = 0; b < NUM_BARRIERS; b++) begin
                count_r[b] <= '0;
                mask_r[b]  <= '0;
            end
            release_valid_r <= 1'b0;
            release_mask_r  <= '0;
        end else begin
            for (int b = 0; b < NUM_BARRIERS; b++) begin
                if (arrive && (bar.id == NB_WIDTH'(b))) begin
                    if (is_final) begin
                        // Global barriers keep their warps parked until the response.
                        count_r[b] <= '0;
                        mask_r[b]  <= arrive_global ? (mask_r[b] | wid_bit) : '0;
                    end else begin
                        count_r[b] <= count_r[b] + NW_WIDTH'(1);
                        mask_r[b]  <= mask_r[b] | wid_bit;
                    end
                end
`ifdef VX_GBAR_EN
                else if (rsp_hit && (rsp.id == NB_WIDTH'(b))) begin
                    mask_r[b] <= '0;
                end
`endif
            end
            release_valid_r <= |(local_rel | rsp_rel);
            release_mask_r  <= local_rel | rsp_rel;
        end
    end

    assign stalled_mask     = stall_or;
    assign release_valid    = release_valid_r;
    assign release_mask     = release_mask_r;
    assign gbar_req_valid   = req_valid;
    assign gbar_req_id      = req_valid ? req.id      : '0;
    assign gbar_req_size_m1 = req_valid ? req.size_m1 : '0;
    assign gbar_req_core_id = req_valid ? req.core_id : '0;

endmodule
